// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
//   Shared widths, types and helpers for the cosine_nco carrier oscillator.
//   - PHASE_W / LUT_ADDR_W / AMP_W : accumulator, full-circle address and
//     signed sample widths.
//   - QUAD_W : address bits inside one quadrant (LUT_ADDR_W-2).
//   - quarter_map()   : full-circle address -> quadrant + quarter-ROM index.
//   - fold_quadrant() : quadrant + unsigned ROM magnitude -> signed sample.
//   - rom_entry()     : elaboration-time quarter-wave cosine table contents.
// -----------------------------------------------------------------------------
package nco_pkg;

  localparam int PHASE_W    = 24;
  localparam int LUT_ADDR_W = 9;
  localparam int AMP_W      = 18;
  localparam int QUAD_W     = LUT_ADDR_W - 2;
  localparam int ROM_DEPTH  = 2**QUAD_W + 1;      // 0..2^Q inclusive
  localparam int ROM_IDX_W  = QUAD_W + 1;
  localparam int AMP_MAX    = 2**(AMP_W-1) - 1;

  typedef logic [PHASE_W-1:0]        phase_t;
  typedef logic [LUT_ADDR_W-1:0]     lut_addr_t;
  typedef logic signed [AMP_W-1:0]   amp_t;
  typedef logic [AMP_W-2:0]          mag_t;
  typedef logic [ROM_IDX_W-1:0]      rom_idx_t;
  typedef logic [1:0]                quad_t;

  typedef struct packed {
    quad_t    quad;
    rom_idx_t idx;
  } rom_req_t;

  // Odd quadrants run the quarter table backwards, so the index is mirrored
  // about 2^Q; idx 0 in an odd quadrant therefore reads the zero entry.
  function automatic rom_req_t quarter_map(input lut_addr_t addr);
    rom_req_t r;
    rom_idx_t i;
    i      = rom_idx_t'(addr[QUAD_W-1:0]);
    r.quad = addr[LUT_ADDR_W-1 -: 2];
    r.idx  = r.quad[0] ? (rom_idx_t'(2**QUAD_W) - i) : i;
    return r;
  endfunction

  // Quadrants 1 and 2 lie left of the imaginary axis: cosine is negative.
  // Negating an unsigned magnitude keeps the range symmetric, so the most
  // negative code is never produced.
  function automatic amp_t fold_quadrant(input quad_t quad, input mag_t mag);
    amp_t m;
    m = amp_t'({1'b0, mag});
    return (quad[1] ^ quad[0]) ? -m : m;
  endfunction

  function automatic mag_t rom_entry(input int k);
    real ang;
    ang = 3.14159265358979323846 / 2.0 * real'(k) / real'(2**QUAD_W);
    return mag_t'($rtoi(real'(AMP_MAX) * $cos(ang) + 0.5));
  endfunction

endpackage

// File: rtl/cosine_quarter_rom.sv
// -----------------------------------------------------------------------------
// cosine_quarter_rom
//   Quarter-wave cosine table with a single registered read port.
//   Ports:
//     clk   in  rising-edge clock
//     rst_n in  synchronous active-low reset (clears the read register)
//     idx   in  quarter-table index, 0..2^QUAD_W
//     data  out unsigned magnitude, one cycle after idx
// -----------------------------------------------------------------------------
module cosine_quarter_rom
  import nco_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  rom_idx_t idx,
  output mag_t     data
);

  mag_t table_q [ROM_DEPTH];

  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_tbl
    assign table_q[k] = rom_entry(k);
  end

  // NOTE: the table itself is constant and is never reset; only the read
  // register is, so reset costs one flop row rather than the whole array.
  always_ff @(posedge clk) begin
    if (!rst_n) data <= '0;
    else        data <= table_q[idx];
  end

endmodule

// File: rtl/cosine_nco.sv
// -----------------------------------------------------------------------------
// cosine_nco
//   Multi-channel NCO: per-channel phase accumulator + phase offset addressing
//   a quarter-wave cosine ROM, 3-stage pipeline, shared valid strobe.
//   Optional quadrature output enabled by defining SINE_OUT_EN.
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   synchronous active-low reset
//     en         in   advance accumulators and launch one sample set
//     clr        in   per-channel accumulator clear (wins over en)
//     fcw        in   per-channel frequency control word, unsigned
//     phase_ofs  in   per-channel phase offset at ROM address (256 = pi)
//     out_valid  out  cos_out (and sin_out) carry a new sample set
//     cos_out    out  per-channel signed cosine samples
//     sin_out    out  per-channel signed sine samples (SINE_OUT_EN only)
//   Latency from the en edge to out_valid/cos_out is 3 cycles.
// -----------------------------------------------------------------------------
module cosine_nco
  import nco_pkg::*;
#(
  parameter int CHANNELS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [CHANNELS-1:0]                  clr,
  input  logic [CHANNELS-1:0][PHASE_W-1:0]     fcw,
  input  logic [CHANNELS-1:0][LUT_ADDR_W-1:0]  phase_ofs,
  output logic                                 out_valid,
  output logic [CHANNELS-1:0][AMP_W-1:0]       cos_out
`ifdef SINE_OUT_EN
  ,
  output logic [CHANNELS-1:0][AMP_W-1:0]       sin_out
`endif
);

  // Valid travels alongside the data; the pipeline itself never stalls.
  logic v1, v2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= en;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    phase_t    acc;
    lut_addr_t addr;
    rom_req_t  cos_req;      // S1
    quad_t     cos_quad_s2;  // S2, aligned with ROM data
    mag_t      cos_mag;      // S2, ROM read register
    amp_t      cos_q;        // S3

    // The launched sample uses acc before this edge's update.
    assign addr = acc[PHASE_W-1 -: LUT_ADDR_W] + phase_ofs[c];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc         <= '0;
        cos_req     <= '0;
        cos_quad_s2 <= '0;
        cos_q       <= '0;
      end else begin
        if (clr[c])  acc <= '0;
        else if (en) acc <= acc + fcw[c];
        cos_req     <= quarter_map(addr);
        cos_quad_s2 <= cos_req.quad;
        if (v2) cos_q <= fold_quadrant(cos_quad_s2, cos_mag);
      end
    end

    cosine_quarter_rom u_cos_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .idx   (cos_req.idx),
      .data  (cos_mag)
    );

    assign cos_out[c] = cos_q;

`ifdef SINE_OUT_EN
    // sin(x) = cos(x - pi/2): same table, address shifted back a quadrant.
    lut_addr_t addr_s;
    rom_req_t  sin_req;
    quad_t     sin_quad_s2;
    mag_t      sin_mag;
    amp_t      sin_q;

    assign addr_s = addr - lut_addr_t'(2**QUAD_W);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sin_req     <= '0;
        sin_quad_s2 <= '0;
        sin_q       <= '0;
      end else begin
        sin_req     <= quarter_map(addr_s);
        sin_quad_s2 <= sin_req.quad;
        if (v2) sin_q <= fold_quadrant(sin_quad_s2, sin_mag);
      end
    end

    cosine_quarter_rom u_sin_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .idx   (sin_req.idx),
      .data  (sin_mag)
    );

    assign sin_out[c] = sin_q;
`endif
  end

endmodule

// File: tb/tb_cosine_nco.sv
// -----------------------------------------------------------------------------
// tb_cosine_nco
//   Self-checking bench for cosine_nco. A phase-level model predicts every
//   sample set from the accumulator arithmetic and ideal cosine symmetry; a
//   negedge compare process checks out_valid/cos_out (and sin_out when
//   SINE_OUT_EN is defined) on every cycle.
// -----------------------------------------------------------------------------
module tb_cosine_nco;
  import nco_pkg::*;

  localparam int CH = 2;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic                            en = 1'b0;
  logic [CH-1:0]                   clr = '0;
  logic [CH-1:0][PHASE_W-1:0]      fcw = '0;
  logic [CH-1:0][LUT_ADDR_W-1:0]   phase_ofs = '0;
  logic                            out_valid;
  logic [CH-1:0][AMP_W-1:0]        cos_out;
`ifdef SINE_OUT_EN
  logic [CH-1:0][AMP_W-1:0]        sin_out;
`endif

  cosine_nco #(.CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .fcw       (fcw),
    .phase_ofs (phase_ofs),
    .out_valid (out_valid),
    .cos_out   (cos_out)
`ifdef SINE_OUT_EN
    ,
    .sin_out   (sin_out)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference: ideal cosine by circle symmetry -------------
  function automatic int mag_q(input int k);
    real ang;
    ang = 3.14159265358979323846 / 2.0 * real'(k) / 128.0;
    return $rtoi(131071.0 * $cos(ang) + 0.5);
  endfunction

  function automatic int model_cos(input int a);
    int m;
    m = a % 512;
    if (m <= 128)      return  mag_q(m);
    else if (m <= 256) return -mag_q(256 - m);
    else if (m <= 384) return -mag_q(m - 256);
    else               return  mag_q(512 - m);
  endfunction

  function automatic int model_sin(input int a);
    return model_cos((a + 384) % 512);
  endfunction

  // ---------------- model: accumulators + launched-sample queue -------------
  typedef struct {
    int due;
    int tag;
    int anti;
    int cs [CH];
    int sn [CH];
  } exp_t;

  exp_t        q [$];
  int          edge_n = 0;
  int          tag = 0;
  longint      macc [CH];
  int          held_cos [CH];
  int          held_sin [CH];
  int          rec_c0 [$];
  int          mark_c0 [$];

  always @(posedge clk) begin
    exp_t e;
    int   a [CH];
    edge_n++;
    if (!rst_n) begin
      q.delete();
      for (int c = 0; c < CH; c++) begin
        macc[c]     = 0;
        held_cos[c] = 0;
        held_sin[c] = 0;
      end
    end else begin
      if (en) begin
        e.due = edge_n + 2;
        e.tag = tag;
        for (int c = 0; c < CH; c++) begin
          a[c]    = int'(((macc[c] >> 15) + longint'(phase_ofs[c])) % 512);
          e.cs[c] = model_cos(a[c]);
          e.sn[c] = model_sin(a[c]);
        end
        e.anti = ((a[1] - a[0] + 512) % 512 == 256) ? 1 : 0;
        q.push_back(e);
      end
      for (int c = 0; c < CH; c++) begin
        if (clr[c])  macc[c] = 0;
        else if (en) macc[c] = (macc[c] + longint'(fcw[c])) % (64'd1 << 24);
      end
    end
  end

  // ---------------- compare process -----------------------------------------
  always @(negedge clk) begin
    exp_t cur;
    logic exp_v;
    if (edge_n >= 1) begin
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        cur   = q.pop_front();
        exp_v = 1'b1;
        for (int c = 0; c < CH; c++) begin
          held_cos[c] = cur.cs[c];
          held_sin[c] = cur.sn[c];
        end
        if (cur.tag == 1) rec_c0.push_back($signed(cos_out[0]));
        if (cur.tag == 2) mark_c0.push_back($signed(cos_out[0]));
        if (cur.anti == 1)
          check("antiphase", $signed(cos_out[1]), -$signed(cos_out[0]));
      end
      check("out_valid", out_valid, exp_v);
      for (int c = 0; c < CH; c++) begin
        check($sformatf("cos_out[%0d]", c), $signed(cos_out[c]), held_cos[c]);
`ifdef SINE_OUT_EN
        check($sformatf("sin_out[%0d]", c), $signed(sin_out[c]), held_sin[c]);
        if (exp_v) begin
          real r;
          real s;
          real k;
          s = real'($signed(sin_out[c]));
          k = real'($signed(cos_out[c]));
          r = $sqrt(s * s + k * k) - 131071.0;
          check("quad_norm", (r <= 2.0 && r >= -2.0) ? 1 : 0, 1);
        end
`endif
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int bad;

    // Pin the reference itself with hand-computed values.
    check("pin_cos_0",   model_cos(0),   131071);
    check("pin_cos_64",  model_cos(64),  92681);
    check("pin_cos_128", model_cos(128), 0);
    check("pin_cos_256", model_cos(256), -131071);
    check("pin_cos_384", model_cos(384), 0);
    check("pin_sin_0",   model_sin(0),   0);
    check("pin_sin_128", model_sin(128), 131071);
    bad = 0;
    for (int a = 0; a < 512; a++) begin
      real d;
      d = real'(model_cos(a)) - 131071.0 * $cos(2.0 * 3.14159265358979323846 * real'(a) / 512.0);
      if (d > 1.0 || d < -1.0) bad++;
    end
    check("pin_ideal_dev", bad, 0);

    // Reset state.
    cycles(2);
    check("reset_valid", out_valid, 0);
    check("reset_cos0", $signed(cos_out[0]), 0);
    rst_n = 1'b1;

    // 1: one address per sample, full circle plus one.
    fcw = {24'h008000, 24'h008000};
    tag = 1;
    en  = 1'b1;
    cycles(513);
    en  = 1'b0;
    tag = 0;
    cycles(5);
    check("t1_count", rec_c0.size(), 513);
    check("t1_addr0",   rec_c0[0],   131071);
    check("t1_addr64",  rec_c0[64],  92681);
    check("t1_addr128", rec_c0[128], 0);
    check("t1_addr256", rec_c0[256], -131071);
    check("t1_addr384", rec_c0[384], 0);
    check("t1_wrap512", rec_c0[512], 131071);

    // 2: ch1 offset by pi -> antiphase.
    clr = 2'b11;
    cycles(1);
    clr = 2'b00;
    phase_ofs[1] = 9'd256;
    en = 1'b1;
    cycles(200);

    // 3: en toggling, odd frequency words.
    fcw = {24'h0ABCDE, 24'h123456};
    phase_ofs = {9'd17, 9'd300};
    for (int i = 0; i < 10; i++) begin
      en = (i % 2 == 0) || (i == 5);
      cycles(1);
    end
    en = 1'b0;
    cycles(5);

    // 4: wrap near 2^24-1 and clear-with-enable.
    clr = 2'b11;
    cycles(1);
    clr = 2'b00;
    phase_ofs = '0;
    fcw = {24'hFFFFFF, 24'hC00001};
    en = 1'b1;
    cycles(6);
    fcw[1] = 24'h800000;
    fcw[0] = 24'h800000;
    cycles(4);
    fcw[0] = 24'hC00001;
    cycles(3);
    clr = 2'b01;
    cycles(1);
    clr = 2'b00;
    tag = 2;
    cycles(1);
    tag = 0;
    cycles(6);
    check("t4_clr_count", mark_c0.size(), 1);
    check("t4_clr_sample", mark_c0[0], 131071);

    // 5: reset pulse mid-stream with en held high.
    fcw = {24'h008000, 24'h008000};
    cycles(10);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t5_gap_valid", out_valid, 0);
      check("t5_gap_cos0", $signed(cos_out[0]), 0);
      cycles(1);
    end
    check("t5_restart_valid", out_valid, 1);
    check("t5_restart_cos0", $signed(cos_out[0]), 131071);
    check("t5_restart_cos1", $signed(cos_out[1]), 131071);

`ifdef SINE_OUT_EN
    // 6: full circle of quadrature samples (norm checked per sample).
    clr = 2'b11;
    cycles(1);
    clr = 2'b00;
    cycles(515);
`endif

    en = 1'b0;
    cycles(6);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
